// File: rtl/balance_pid_pipe.sv
// rtl/balance_pid_pipe.sv - pipelined balance PID with soft-start ramp and motor speed shaping
module balance_pid_pipe #(
    parameter int PTCH_ERR_W      = 10,
    parameter int P_COEFF         = 14,
    parameter int D_COEFF         = 20,
    parameter int D_DEPTH         = 2,
    parameter int I_SHIFT         = 6,
    parameter int SPD_W           = 11,
    parameter int LOW_TORQUE_BAND = 70,
    parameter int GAIN_MULT       = 15,
    parameter int MIN_DUTY        = 980,
    parameter int RAMP_STEP       = 16,
    parameter int TOO_FAST_THR    = 1536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic [15:0]      ptch,
    input  logic [11:0]      ld_cell_diff,
    input  logic             en_steer,
    input  logic             rider_off,
    input  logic             pwr_up,
    output logic [SPD_W-1:0] lft_spd,
    output logic [SPD_W-1:0] rght_spd,
    output logic             lft_rev,
    output logic             rght_rev,
    output logic             spd_vld,
    output logic             too_fast,
    output logic             ramp_done
);
    localparam int IW      = PTCH_ERR_W + 8;
    localparam int DW      = PTCH_ERR_W - 3;
    localparam int ERR_MAX = (1 << (PTCH_ERR_W - 1)) - 1;
    localparam int ERR_MIN = -(1 << (PTCH_ERR_W - 1));
    localparam int DIF_MAX = (1 << (DW - 1)) - 1;
    localparam int DIF_MIN = -(1 << (DW - 1));
    localparam int INT_MAX = (1 << (IW - 1)) - 1;
    localparam int INT_MIN = -(1 << (IW - 1));
    localparam int SPD_MAX = (1 << SPD_W) - 1;

    typedef enum logic [1:0] {ST_OFF, ST_RAMP, ST_RUN} state_t;

    state_t                       state_q, state_d;
    logic [SPD_W-1:0]             ramp_lim_q, ramp_lim_d;
    logic signed [PTCH_ERR_W-1:0] hist_q [D_DEPTH];
    logic signed [PTCH_ERR_W-1:0] hist_d [D_DEPTH];
    logic signed [IW-1:0]         integ_q, integ_d;

    logic                         v1_q, v1_d;
    logic signed [PTCH_ERR_W-1:0] err_q, err_d, err_c;
    logic signed [DW-1:0]         dif_q, dif_d;
    logic signed [IW-1:0]         i_q, i_d;
    logic signed [11:0]           ld_q, ld_d;
    logic                         en_q, en_d;

    logic                         v2_q, v2_d;
    logic signed [15:0]           lt_q, lt_d, rt_q, rt_d, pid_c;

    logic [SPD_W-1:0]             lft_spd_q, lft_spd_d, rght_spd_q, rght_spd_d;
    logic                         lft_rev_q, lft_rev_d, rght_rev_q, rght_rev_d;
    logic                         spd_vld_q, spd_vld_d, too_fast_q, too_fast_d;
    logic [SPD_W:0]               lsh, rsh;

    int ramp_sum, ptch_i, dif_i, sum_i, pid_i, s_i;
    logic clr;

    // returns {rev, spd}: offset above the band, gain inside it, then clamp to full scale and ramp
    function automatic logic [SPD_W:0] shape(input logic signed [15:0] t, input logic [SPD_W-1:0] lim);
        int ti, sh, mag;
        ti = int'(t);
        if (ti >= LOW_TORQUE_BAND)       sh = ti + MIN_DUTY;
        else if (ti <= -LOW_TORQUE_BAND) sh = ti - MIN_DUTY;
        else                             sh = ti * GAIN_MULT;
        mag = (sh < 0) ? -sh : sh;
        if (mag > SPD_MAX)    mag = SPD_MAX;
        if (mag > int'(lim))  mag = int'(lim);
        return {sh < 0, SPD_W'(mag)};
    endfunction

    always_comb begin
        state_d    = state_q;
        ramp_lim_d = ramp_lim_q;
        ramp_sum   = int'(ramp_lim_q) + RAMP_STEP;
        if (!pwr_up) begin
            state_d    = ST_OFF;
            ramp_lim_d = '0;
        end else begin
            if (vld && state_q != ST_RUN)
                ramp_lim_d = (ramp_sum >= SPD_MAX) ? SPD_W'(SPD_MAX) : SPD_W'(ramp_sum);
            case (state_q)
                ST_OFF:  state_d = (ramp_lim_d == SPD_W'(SPD_MAX)) ? ST_RUN : ST_RAMP;
                ST_RAMP: if (ramp_lim_d == SPD_W'(SPD_MAX)) state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        ptch_i = int'($signed(ptch));
        if (ptch_i > ERR_MAX)      err_c = PTCH_ERR_W'(ERR_MAX);
        else if (ptch_i < ERR_MIN) err_c = PTCH_ERR_W'(ERR_MIN);
        else                       err_c = PTCH_ERR_W'(ptch_i);

        dif_i = int'(err_c) - int'(hist_q[D_DEPTH-1]);
        if (dif_i > DIF_MAX)      dif_i = DIF_MAX;
        else if (dif_i < DIF_MIN) dif_i = DIF_MIN;

        hist_d = hist_q;
        if (vld) begin
            hist_d[0] = err_c;
            for (int i = 1; i < D_DEPTH; i++) hist_d[i] = hist_q[i-1];
        end

        clr     = !pwr_up || rider_off;
        sum_i   = int'(integ_q) + int'(err_c);
        integ_d = integ_q;
        if (clr)
            integ_d = '0;
        else if (vld && sum_i <= INT_MAX && sum_i >= INT_MIN)
            integ_d = IW'(sum_i);

        v1_d  = vld && pwr_up;
        err_d = vld ? err_c : err_q;
        dif_d = vld ? DW'(dif_i) : dif_q;
        i_d   = i_q;
        if (vld) i_d = clr ? '0 : (integ_q >>> I_SHIFT);
        ld_d  = vld ? $signed(ld_cell_diff) : ld_q;
        en_d  = vld ? en_steer : en_q;
    end

    // stage 2 arithmetic is deliberately evaluated at 16 bits signed
    always_comb begin
        pid_i = int'(err_q) * P_COEFF + int'(dif_q) * D_COEFF + int'(i_q);
        pid_c = 16'(pid_i);
        s_i   = en_q ? (int'(ld_q) >>> 3) : 0;
        v2_d  = v1_q && pwr_up;
        lt_d  = v1_q ? 16'(int'(pid_c) - s_i) : lt_q;
        rt_d  = v1_q ? 16'(int'(pid_c) + s_i) : rt_q;
    end

    always_comb begin
        lsh        = shape(lt_q, ramp_lim_q);
        rsh        = shape(rt_q, ramp_lim_q);
        lft_spd_d  = lft_spd_q;
        rght_spd_d = rght_spd_q;
        lft_rev_d  = lft_rev_q;
        rght_rev_d = rght_rev_q;
        too_fast_d = too_fast_q;
        spd_vld_d  = 1'b0;
        if (!pwr_up) begin
            lft_spd_d  = '0;
            rght_spd_d = '0;
            lft_rev_d  = 1'b0;
            rght_rev_d = 1'b0;
            too_fast_d = 1'b0;
        end else if (v2_q) begin
            lft_spd_d  = lsh[SPD_W-1:0];
            rght_spd_d = rsh[SPD_W-1:0];
            lft_rev_d  = lsh[SPD_W];
            rght_rev_d = rsh[SPD_W];
            too_fast_d = (int'(lsh[SPD_W-1:0]) > TOO_FAST_THR) || (int'(rsh[SPD_W-1:0]) > TOO_FAST_THR);
            spd_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_OFF;
            ramp_lim_q <= '0;
            for (int i = 0; i < D_DEPTH; i++) hist_q[i] <= '0;
            integ_q    <= '0;
            v1_q       <= 1'b0;
            err_q      <= '0;
            dif_q      <= '0;
            i_q        <= '0;
            ld_q       <= '0;
            en_q       <= 1'b0;
            v2_q       <= 1'b0;
            lt_q       <= '0;
            rt_q       <= '0;
            lft_spd_q  <= '0;
            rght_spd_q <= '0;
            lft_rev_q  <= 1'b0;
            rght_rev_q <= 1'b0;
            spd_vld_q  <= 1'b0;
            too_fast_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ramp_lim_q <= ramp_lim_d;
            hist_q     <= hist_d;
            integ_q    <= integ_d;
            v1_q       <= v1_d;
            err_q      <= err_d;
            dif_q      <= dif_d;
            i_q        <= i_d;
            ld_q       <= ld_d;
            en_q       <= en_d;
            v2_q       <= v2_d;
            lt_q       <= lt_d;
            rt_q       <= rt_d;
            lft_spd_q  <= lft_spd_d;
            rght_spd_q <= rght_spd_d;
            lft_rev_q  <= lft_rev_d;
            rght_rev_q <= rght_rev_d;
            spd_vld_q  <= spd_vld_d;
            too_fast_q <= too_fast_d;
        end
    end

    assign lft_spd   = lft_spd_q;
    assign rght_spd  = rght_spd_q;
    assign lft_rev   = lft_rev_q;
    assign rght_rev  = rght_rev_q;
    assign spd_vld   = spd_vld_q;
    assign too_fast  = too_fast_q;
    assign ramp_done = (state_q == ST_RUN);
endmodule

// File: tb/tb_balance_pid_pipe.sv
// tb/tb_balance_pid_pipe.sv - scoreboard and vector-table bench for balance_pid_pipe
module tb_balance_pid_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [15:0] ptch = '0;
    logic [11:0] ld = '0;
    logic        en_steer = 1'b0;
    logic        rider_off = 1'b0;
    logic        pwr_up = 1'b0;
    logic [10:0] lft_spd, rght_spd;
    logic        lft_rev, rght_rev, spd_vld, too_fast, ramp_done;

    balance_pid_pipe dut (
        .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ld_cell_diff(ld),
        .en_steer(en_steer), .rider_off(rider_off), .pwr_up(pwr_up),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .lft_rev(lft_rev), .rght_rev(rght_rev),
        .spd_vld(spd_vld), .too_fast(too_fast), .ramp_done(ramp_done)
    );

    always #5 clk = ~clk;

    typedef struct {int ls; bit lr; int rs; bit rr; bit tf; int cyc;} exp_t;
    typedef struct {int p; int l; bit en; bit ro; int ls; bit lr; int rs; bit rr; bit tf; int gap;} vec_t;

    exp_t sb[$];
    exp_t got;
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (spd_vld) begin
            if (sb.size() == 0) begin
                chk("unexpected_spd_vld", 1, 0);
            end else begin
                got = sb.pop_front();
                chk("lft_spd", lft_spd, got.ls);
                chk("lft_rev", lft_rev, got.lr);
                chk("rght_spd", rght_spd, got.rs);
                chk("rght_rev", rght_rev, got.rr);
                chk("too_fast", too_fast, got.tf);
                chk("latency", cyc - got.cyc, 3);
            end
        end
    end

    task automatic send(input int p, input int l, input bit en, input bit ro, input bit push,
                        input int ls, input bit lr, input int rs, input bit rr, input bit tf, input int gap);
        exp_t x;
        ptch = p[15:0];
        ld = l[11:0];
        en_steer = en;
        rider_off = ro;
        vld = 1'b1;
        if (push) begin
            x.ls = ls; x.lr = lr; x.rs = rs; x.rr = rr; x.tf = tf; x.cyc = cyc;
            sb.push_back(x);
        end
        @(posedge clk); #1;
        vld = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(negedge clk); #1; n++; end
        chk("drain_pending", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        // rows: ptch, ld, en, ro, lft_spd, lft_rev, rght_spd, rght_rev, too_fast, gap
        vecs.push_back('{2,    0, 0, 1, 2047, 1, 2047, 1, 1, 0});
        vecs.push_back('{2,    0, 0, 1, 2047, 1, 2047, 1, 1, 0});
        vecs.push_back('{2,    0, 0, 1,  420, 0,  420, 0, 0, 0});
        vecs.push_back('{2,    0, 0, 1,  420, 0,  420, 0, 0, 0});
        vecs.push_back('{2,    0, 0, 1,  420, 0,  420, 0, 0, 3});
        vecs.push_back('{2,  800, 1, 1, 1052, 1, 1108, 0, 0, 1});
        vecs.push_back('{2,  800, 1, 1, 1052, 1, 1108, 0, 0, 1});
        vecs.push_back('{2, -800, 1, 1, 1108, 0, 1052, 1, 0, 1});
        vecs.push_back('{2,  800, 0, 1,  420, 0,  420, 0, 0, 1});
        vecs.push_back('{5,    0, 0, 1, 1110, 0, 1110, 0, 0, 0});
        vecs.push_back('{5,    0, 0, 1, 1110, 0, 1110, 0, 0, 0});
        vecs.push_back('{5,    0, 0, 1, 1050, 0, 1050, 0, 0, 0});
        vecs.push_back('{4,    0, 0, 1,  540, 0,  540, 0, 0, 0});
        vecs.push_back('{4,    0, 0, 1,  540, 0,  540, 0, 0, 0});
        vecs.push_back('{4,    0, 0, 1,  840, 0,  840, 0, 0, 2});
        vecs.push_back('{-5,   0, 0, 1, 1230, 1, 1230, 1, 0, 0});
        vecs.push_back('{-5,   0, 0, 1, 1230, 1, 1230, 1, 0, 0});
        vecs.push_back('{-5,   0, 0, 1, 1050, 1, 1050, 1, 0, 0});
        vecs.push_back('{0,    0, 0, 1, 1080, 0, 1080, 0, 0, 0});
        vecs.push_back('{0,    0, 0, 1, 1080, 0, 1080, 0, 0, 0});
        vecs.push_back('{0,    0, 0, 1,    0, 0,    0, 0, 0, 1});

        // reset with random inputs
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            vld = 1'($urandom_range(0, 1));
            ptch = 16'($urandom);
            ld = 12'($urandom);
            en_steer = 1'($urandom_range(0, 1));
            rider_off = 1'($urandom_range(0, 1));
            pwr_up = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("reset_outputs", int'({lft_spd, rght_spd, lft_rev, rght_rev, spd_vld, too_fast, ramp_done}), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; vld = 1'b0; pwr_up = 1'b0; rider_off = 1'b0; en_steer = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
            chk("off_lft_spd", lft_spd, 0);
            chk("off_rght_spd", rght_spd, 0);
            chk("off_spd_vld", spd_vld, 0);
        end

        // soft-start: one sample every 4 cycles so stage 3 sees the ramp from its own sample
        pwr_up = 1'b1;
        for (int k = 1; k <= 128; k++) begin
            e = (16 * k > 2047) ? 2047 : 16 * k;
            if (k == 128) chk("ramp_done_before_128", ramp_done, 0);
            send(500, 0, 0, 0, 1, e, 0, e, 0, e > 1536, 3);
        end
        drain();
        chk("ramp_done_after_128", ramp_done, 1);

        // low band, steering and band edges, integrator held clear
        rider_off = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        foreach (vecs[i])
            send(vecs[i].p, vecs[i].l, vecs[i].en, vecs[i].ro, 1, vecs[i].ls, vecs[i].lr,
                 vecs[i].rs, vecs[i].rr, vecs[i].tf, vecs[i].gap);
        drain();

        // saturation and integrator hold at +max (256 adds of 511 reach 130816)
        for (int i = 0; i < 300; i++)
            send(30000, 0, 0, 0, 1, 2047, 0, 2047, 0, 1, 0);
        send(0, 0, 0, 0, 1, 1744, 0, 1744, 0, 1, 0);
        send(0, 0, 0, 0, 1, 1744, 0, 1744, 0, 1, 0);
        send(0, 0, 0, 0, 1, 2047, 0, 2047, 0, 1, 0);
        drain();

        // power drop one cycle after a sample: that sample is flushed
        send(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pwr_up = 1'b0;
        @(posedge clk); #1;
        chk("drop_lft_spd", lft_spd, 0);
        chk("drop_rght_spd", rght_spd, 0);
        chk("drop_too_fast", too_fast, 0);
        chk("drop_ramp_done", ramp_done, 0);
        chk("drop_integrator", int'(dut.integ_q), 0);
        repeat (8) begin
            @(negedge clk);
            chk("drop_no_spd_vld", spd_vld, 0);
        end
        chk("final_queue_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/balance_pid_pipe.md
# balance_pid_pipe

Parametrised, pipelined successor to the segway balance PID controller. It takes pitch samples from the inertial interface and load-cell difference from the steering-enable block. It computes P, I and D terms with configurable gains, widths and derivative history depth, then shapes torque into left and right motor speed and direction for the PWM/motor drive blocks. Compared with the previous block it adds a 3-stage registered pipeline with a `spd_vld` strobe, a power-up soft-start ramp state machine, and a configurable over-speed threshold.

## Interface
- `PTCH_ERR_W`, 10: saturated pitch-error width (signed).
- `P_COEFF`, 14: proportional gain (unsigned).
- `D_COEFF`, 20: derivative gain (unsigned).
- `D_DEPTH`, 2: samples back used for the derivative difference (≥1).
- `I_SHIFT`, 6: integrator right-shift to form the I term.
- `SPD_W`, 11: motor speed width.
- `LOW_TORQUE_BAND`, 70: threshold between gain-multiplied and offset regions.
- `GAIN_MULT`, 15: low-band gain.
- `MIN_DUTY`, 980: duty offset above the low band.
- `RAMP_STEP`, 16: soft-start limit increment per `vld`.
- `TOO_FAST_THR`, 1536: over-speed threshold.
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `vld` in 1: single-cycle strobe, new pitch sample.
- `ptch` in 16: signed pitch.
- `ld_cell_diff` in 12: signed left minus right load.
- `en_steer` in 1: apply steering differential.
- `rider_off` in 1: clears and holds the integrator.
- `pwr_up` in 1: enables the block.
- `lft_spd` / `rght_spd` out SPD_W: unsigned motor speeds.
- `lft_rev` / `rght_rev` out 1: reverse direction flags.
- `spd_vld` out 1: 1-cycle pulse when outputs update.
- `too_fast` out 1: registered over-speed flag.
- `ramp_done` out 1: high while in RUN.

## Operation
- **State machine** (registered):
  - OFF to RAMP when `pwr_up`=1.
  - RAMP to RUN when `ramp_lim` reaches 2^SPD_W−1.
  - Any state to OFF when `pwr_up`=0.
- **Ramp limit:**
  - `ramp_lim` is 0 in OFF.
  - In RAMP, each `vld` adds RAMP_STEP, saturating at 2^SPD_W−1.
  - With defaults, RUN is entered on the 128th `vld`.
- **Stage 1**, on a cycle with `vld`:
  - Saturate `ptch` to PTCH_ERR_W signed (ranges −512..511 by default) to form `err`.
  - Push `err` into a D_DEPTH-deep history; the history resets to 0.
  - `d_diff` = `err` − history[D_DEPTH−1], saturated to PTCH_ERR_W−3 bits signed (−64..63).
  - Register `err` and `d_diff`.
- **Integrator** (PTCH_ERR_W+8 bits signed):
  - On a `vld`, add sign-extended `err` unless the add would overflow; on overflow, hold the value.
  - `rider_off`=1 or state OFF forces it to 0.
  - The I term is the accumulator value before the current addition, arithmetically shifted right by I_SHIFT.
- **Stage 2:**
  - `pid` = `err`·P_COEFF + `d_diff`·D_COEFF + I, computed at 16 bits signed.
  - Steering term `s` = `ld_cell_diff` >>> 3.
  - If `en_steer`: `lft_t` = `pid` − `s` and `rght_t` = `pid` + `s`. Otherwise both equal `pid`.
- **Stage 3**, per side:
  - If |t| ≥ LOW_TORQUE_BAND: shaped = t ± MIN_DUTY, with the sign of t.
  - Otherwise: shaped = t·GAIN_MULT.
  - `rev` = sign of shaped.
  - `spd` = min(|shaped|, 2^SPD_W−1, `ramp_lim`).
  - `too_fast` = either `spd` > TOO_FAST_THR.
- **Hold and OFF behaviour:**
  - Outputs hold between updates.
  - In OFF, speeds, `rev`, `too_fast` and `spd_vld` are 0.

## Timing
- Reset values:
  - all outputs 0;
  - state OFF;
  - integrator, history, pipeline registers and `ramp_lim` all 0.
- Latency:
  - `vld` in cycle N produces `spd_vld` and the updated outputs in cycle N+3.
  - Back-to-back `vld` is supported, at one sample per cycle.
- `pwr_up` deasserted:
  - In the next cycle, state is OFF, outputs are 0 and all in-flight pipeline valids are flushed.
  - No `spd_vld` is issued for flushed samples.
- `rst` asserted mid-pipeline: every register clears immediately, asynchronously.
- `vld` in the same cycle as `pwr_up` rising: the sample is processed, and the ramp increments on that same `vld`.
- `ramp_lim` used in stage 3 is the value registered at the time of stage 3.

## Test plan
1. **Reset.** Assert `rst` with random inputs -> all outputs 0; after release with `pwr_up`=0 and `vld` pulsing, `spd_vld` stays 0 and speeds stay 0.
2. **Soft-start.** Set `pwr_up`=1 and apply 128 `vld` pulses with `ptch`=500 -> `spd` never exceeds 16·k after the k-th sample; `ramp_done` rises after the 128th; `spd` then reaches 2047 and `too_fast`=1.
3. **Low band.** In RUN with `rider_off`=1 and `ptch`=2 constant (≥2 samples) -> `lft_spd`=`rght_spd`=420, `rev`=0, `spd_vld` exactly 3 cycles after each `vld`.
4. **Steering.** As test 3 plus `en_steer`=1 and `ld_cell_diff`=800 -> `lft_rev`=1 with `lft_spd`=1052; `rght_rev`=0 with `rght_spd`=1108.
5. **Saturation.** In RUN with `ptch`=+30000 after `ptch`=0 history -> `err`=511 and `d_diff`=63; `lft_spd`=2047; the integrator holds rather than wraps when driven to +max over many samples.
6. **Power drop.** Deassert `pwr_up` one cycle after a `vld` -> the next cycle has speeds 0 and state OFF, no `spd_vld` follows, and the integrator is 0.
